// File: rtl/alu_share_sequencer.sv
// rtl/alu_share_sequencer.sv - round-robin sharing of one 74181-style ALU between two requesters
// Optional build macro ALU_ZERO_FLAG_EN adds a captured resp_zero flag.
module alu_share_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       s0,
    input  logic [3:0]       s1,
    input  logic             m0,
    input  logic             m1,
    input  logic             cn0,
    input  logic             cn1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cn,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cn16,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_f,
    output logic             resp_cn16,
`ifdef ALU_ZERO_FLAG_EN
    output logic             resp_zero,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic       last_gnt;
    logic       id_q;
    logic [3:0] cnt;
    logic       pick;
    logic       grant;
    logic       settle_done;

    // Tie goes to the requester not granted last; a lone request always wins.
    assign pick        = (req0 && req1) ? ~last_gnt : req1;
    assign grant       = (state == IDLE) && (req0 || req1) && !rst;
    assign settle_done = (state == EXEC) && (cnt == CNT_LAST);

    assign gnt0       = grant && !pick;
    assign gnt1       = grant && pick;
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = EXEC;
            EXEC:    if (settle_done) state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            id_q      <= 1'b0;
            cnt       <= 4'd0;
            alu_s     <= 4'd0;
            alu_m     <= 1'b0;
            alu_cn    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            resp_id   <= 1'b0;
            resp_f    <= '0;
            resp_cn16 <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            resp_zero <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (grant) begin
                alu_s    <= pick ? s1  : s0;
                alu_m    <= pick ? m1  : m0;
                alu_cn   <= pick ? cn1 : cn0;
                alu_a    <= pick ? a1  : a0;
                alu_b    <= pick ? b1  : b0;
                id_q     <= pick;
                last_gnt <= pick;
                cnt      <= 4'd0;
            end
            if (state == EXEC) begin
                cnt <= cnt + 4'd1;
            end
            // ALU outputs are taken as-is once the inputs have been stable long enough.
            if (settle_done) begin
                resp_f    <= alu_f;
                resp_cn16 <= alu_cn16;
                resp_id   <= id_q;
`ifdef ALU_ZERO_FLAG_EN
                resp_zero <= (alu_f == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// tb/tb_alu_share_sequencer.sv - directed self-checking bench for alu_share_sequencer
module tb_alu_share_sequencer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [W:0] alu_model(input logic [3:0] s, input logic m, input logic cn,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        if (m) begin
            case (s)
                4'b0110: r = {1'b0, a ^ b};
                4'b1011: r = {1'b0, a & b};
                4'b1110: r = {1'b0, a | b};
                default: r = {1'b0, a};
            endcase
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cn};
        end
        return r;
    endfunction

    // Instance with SETTLE_CYCLES=1
    logic req0 = 0, req1 = 0, m0 = 0, m1 = 0, cn0 = 0, cn1 = 0, resp_ready = 1;
    logic [3:0] s0 = 0, s1 = 0;
    logic [W-1:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
    logic gnt0, gnt1, alu_m, alu_cn, alu_cn16, resp_valid, resp_id, resp_cn16, busy;
    logic [3:0] alu_s;
    logic [W-1:0] alu_a, alu_b, alu_f, resp_f;
    logic resp_zero;

    always_comb {alu_cn16, alu_f} = alu_model(alu_s, alu_m, alu_cn, alu_a, alu_b);

    alu_share_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .s0(s0), .s1(s1), .m0(m0), .m1(m1),
        .cn0(cn0), .cn1(cn1), .a0(a0), .a1(a1), .b0(b0), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
        .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_cn16(alu_cn16), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_f(resp_f), .resp_cn16(resp_cn16),
`ifdef ALU_ZERO_FLAG_EN
        .resp_zero(resp_zero),
`endif
        .busy(busy)
    );
`ifndef ALU_ZERO_FLAG_EN
    assign resp_zero = 1'b0;
`endif

    // Instance with SETTLE_CYCLES=3
    logic x_req0 = 0, x_m0 = 0;
    logic [3:0] x_s0 = 0;
    logic [W-1:0] x_a0 = 0, x_b0 = 0;
    logic x_gnt0, x_gnt1, x_alu_m, x_alu_cn, x_alu_cn16, x_resp_valid, x_resp_id, x_resp_cn16, x_busy;
    logic [3:0] x_alu_s;
    logic [W-1:0] x_alu_a, x_alu_b, x_alu_f, x_resp_f;
`ifdef ALU_ZERO_FLAG_EN
    logic x_resp_zero;
`endif

    always_comb {x_alu_cn16, x_alu_f} = alu_model(x_alu_s, x_alu_m, x_alu_cn, x_alu_a, x_alu_b);

    alu_share_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req0(x_req0), .req1(1'b0), .s0(x_s0), .s1(4'd0), .m0(x_m0), .m1(1'b0),
        .cn0(1'b0), .cn1(1'b0), .a0(x_a0), .a1('0), .b0(x_b0), .b1('0), .gnt0(x_gnt0), .gnt1(x_gnt1),
        .alu_s(x_alu_s), .alu_m(x_alu_m), .alu_cn(x_alu_cn), .alu_a(x_alu_a), .alu_b(x_alu_b),
        .alu_f(x_alu_f), .alu_cn16(x_alu_cn16), .resp_valid(x_resp_valid), .resp_ready(1'b1),
        .resp_id(x_resp_id), .resp_f(x_resp_f), .resp_cn16(x_resp_cn16),
`ifdef ALU_ZERO_FLAG_EN
        .resp_zero(x_resp_zero),
`endif
        .busy(x_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] held_f;
    logic         exp_id;

    initial begin
        // Reset state
        #2;
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_resp_f", resp_f, 0);
        tick(); tick();
        rst = 1'b0;

        // Single logic op from requester 0
        req0 = 1; a0 = 16'h0F0F; b0 = 16'h00FF; s0 = 4'b0110; m0 = 1; cn0 = 1;
        #1;
        check("single_gnt0", gnt0, 1);
        check("single_gnt1", gnt1, 0);
        tick(); req0 = 0;
        check("single_gnt_pulse", gnt0, 0);
        check("single_busy", busy, 1);
        check("single_alu_a", alu_a, 16'h0F0F);
        check("single_alu_s", alu_s, 4'b0110);
        check("single_valid_early", resp_valid, 0);
        tick();
        check("single_valid", resp_valid, 1);
        check("single_f", resp_f, 16'h0FF0);
        check("single_id", resp_id, 0);
        tick();
        check("single_done", resp_valid, 0);
        check("single_idle", busy, 0);

        // Ties after reset alternate starting with requester 0
        rst = 1; #1; rst = 0;
        a0 = 16'h1234; b0 = 16'h00FF; s0 = 4'b0110; m0 = 1;
        a1 = 16'hAAAA; b1 = 16'h5555; s1 = 4'b0110; m1 = 1;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 10; i++) begin
            exp_id = i[0];
            #1;
            check("tie_gnt", {gnt0, gnt1}, exp_id ? 2'b01 : 2'b10);
            tick(); tick();
            check("tie_id", resp_id, exp_id);
            check("tie_f", resp_f, exp_id ? 16'hFFFF : 16'h12CB);
            tick();
        end
        req0 = 0; req1 = 0;

        // Backpressure with requester 1 waiting
        req0 = 1; #1;
        check("bp_gnt0", gnt0, 1);
        tick(); req0 = 0;
        req1 = 1; a1 = 16'hFFFF; b1 = 16'h0001; s1 = 4'b1001; m1 = 0; cn1 = 0;
        resp_ready = 0;
        tick();
        held_f = resp_f;
        check("bp_f_value", held_f, 16'h12CB);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", resp_valid, 1);
            check("bp_f_hold", resp_f, held_f);
            check("bp_no_gnt", gnt1, 0);
            tick();
        end
        resp_ready = 1; #1;
        tick();
        check("bp_released", resp_valid, 0);
        check("bp_gnt1", gnt1, 1);

        // Arithmetic path: FFFF + 0001 wraps to zero with carry out
        tick(); req1 = 0;
        tick();
        check("arith_valid", resp_valid, 1);
        check("arith_f", resp_f, 16'h0000);
        check("arith_cn16", resp_cn16, 1);
        check("arith_id", resp_id, 1);
`ifdef ALU_ZERO_FLAG_EN
        check("arith_zero", resp_zero, 1);
`endif
        tick();

        // Async reset mid-EXEC
        req0 = 1; req1 = 1; #1;
        tick(); req0 = 0; req1 = 0;
        check("arst_pre_busy", busy, 1);
        #2 rst = 1; #1;
        check("arst_busy", busy, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_s", alu_s, 0);
        check("arst_valid", resp_valid, 0);
        check("arst_resp_f", resp_f, 0);
        tick(); rst = 0;
        tick(); tick();
        check("arst_no_resp", resp_valid, 0);
        req0 = 1; req1 = 1; #1;
        check("arst_tie_gnt", {gnt0, gnt1}, 2'b10);
        tick(); req0 = 0; req1 = 0;
        tick(); tick();

        // SETTLE_CYCLES=3: inputs held three cycles, response four cycles after grant
        x_req0 = 1; x_a0 = 16'hF0F0; x_b0 = 16'hFF00; x_s0 = 4'b1011; x_m0 = 1; #1;
        check("s3_gnt", x_gnt0, 1);
        for (int i = 1; i <= 3; i++) begin
            tick(); x_req0 = 0;
            check("s3_alu_a_stable", x_alu_a, 16'hF0F0);
            check("s3_alu_b_stable", x_alu_b, 16'hFF00);
            check("s3_not_valid", x_resp_valid, 0);
        end
        tick();
        check("s3_valid", x_resp_valid, 1);
        check("s3_f", x_resp_f, 16'hF000);
        tick();
        check("s3_done", x_resp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
